// File: rtl/read_responder.sv
// read_responder: returns CPU read data from the register bank (addresses below NUM_REGS) or from
// RAM through a strobe/ready handshake. Define RD_TIMEOUT_EN to bound RAM waits by RAM_TIMEOUT.
module read_responder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_REGS    = 17,
  parameter int unsigned RAM_TIMEOUT = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       rd_req_i,
  input  logic [15:0]                add_i,
  input  logic [NUM_REGS*DATA_W-1:0] reg_q_i,
  output logic                       ram_rd_o,
  output logic [15:0]                ram_add_o,
  input  logic [DATA_W-1:0]          ram_data_i,
  input  logic                       ram_rdy_i,
  output logic                       busy_o,
  output logic                       rd_ack_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       rd_err_o
);

  typedef enum logic [1:0] {StIdle, StRegRd, StRamWait} state_e;

  state_e            state_q;
  logic [15:0]       addr_q;
  logic [15:0]       ram_add_q;
  logic              ram_rd_q;
  logic              rd_ack_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] reg_sel;

`ifdef RD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(RAM_TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;
  logic            rd_err_q;
  logic            timeout;

  assign timeout  = (cnt_q == CntW'(RAM_TIMEOUT - 1));
  assign rd_err_o = rd_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (RAM_TIMEOUT == 0);
  assign rd_err_o           = 1'b0;
`endif

  // Register slice picked by the captured address; only consulted in StRegRd.
  always_comb begin
    reg_sel = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (addr_q == 16'(k)) reg_sel = reg_q_i[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      ram_add_q <= '0;
      ram_rd_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
`ifdef RD_TIMEOUT_EN
      cnt_q     <= '0;
      rd_err_q  <= 1'b0;
`endif
    end else begin
      rd_ack_q <= 1'b0;
`ifdef RD_TIMEOUT_EN
      rd_err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (rd_req_i) begin
            addr_q <= add_i;
            if (add_i < 16'(NUM_REGS)) begin
              state_q <= StRegRd;
            end else begin
              ram_add_q <= add_i;
              ram_rd_q  <= 1'b1;
`ifdef RD_TIMEOUT_EN
              cnt_q     <= '0;
`endif
              state_q   <= StRamWait;
            end
          end
        end
        StRegRd: begin
          rd_data_q <= reg_sel;
          rd_ack_q  <= 1'b1;
          state_q   <= StIdle;
        end
        StRamWait: begin
          // Ready takes priority over a timeout landing on the same edge.
          if (ram_rdy_i) begin
            rd_data_q <= ram_data_i;
            rd_ack_q  <= 1'b1;
            ram_rd_q  <= 1'b0;
            state_q   <= StIdle;
          end else begin
`ifdef RD_TIMEOUT_EN
            cnt_q <= cnt_q + 1'b1;
            if (timeout) begin
              rd_data_q <= '1;
              rd_ack_q  <= 1'b1;
              rd_err_q  <= 1'b1;
              ram_rd_q  <= 1'b0;
              state_q   <= StIdle;
            end
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ram_rd_o  = ram_rd_q;
  assign ram_add_o = ram_add_q;
  assign busy_o    = (state_q != StIdle);
  assign rd_ack_o  = rd_ack_q;
  assign rd_data_o = rd_data_q;

endmodule
